// File: rtl/mmu09_bus_monitor_if.sv
// Signal bundle between the MMU09 CPU-side bus driver (master) and the bus monitor (slave):
// quadrature clocks, address/R/W/data, the capture FIFO read port and the status outputs.
interface mmu09_bus_monitor_if;
    logic        qclk;
    logic        eclk;
    logic [15:0] vadr;
    logic        rw;
    logic [7:0]  data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_addr;
    logic        out_rw;
    logic [7:0]  out_data;
    logic [31:0] cyc_count;
    logic        stop;
    logic        phase_err;
    logic        overflow;

    modport master (
        output qclk, eclk, vadr, rw, data, out_ready,
        input  out_valid, out_addr, out_rw, out_data, cyc_count, stop, phase_err, overflow
    );

    modport slave (
        input  qclk, eclk, vadr, rw, data, out_ready,
        output out_valid, out_addr, out_rw, out_data, cyc_count, stop, phase_err, overflow
    );
endinterface

// File: rtl/mmu09_bus_monitor.sv
// Passive 6809 bus observer: checks the E/Q phase sequence, rebuilds each bus cycle and
// queues completed cycles in a small FIFO, with cycle counting and sticky stop/error flags.
module mmu09_bus_monitor #(
    parameter logic [15:0] STOP_ADDR  = 16'hFFF0,
    parameter int          FIFO_DEPTH = 4
) (
    input logic                clk,
    input logic                reset,
    mmu09_bus_monitor_if.slave bus
);
    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [2:0] ST_UNSYNC = 3'd0;
    localparam logic [2:0] ST_PH00   = 3'd1;
    localparam logic [2:0] ST_PH01   = 3'd2;
    localparam logic [2:0] ST_PH11   = 3'd3;
    localparam logic [2:0] ST_PH10   = 3'd4;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

    logic        qS_q;
    logic        eS_q;
    logic [15:0] adrS_q;
    logic        rwS_q;
    logic [7:0]  datS_q;
    logic [1:0]  phaseP_q;
    logic [1:0]  phaseS;

    logic [2:0]  state_q, state_d;
    logic [15:0] addr_q, addr_d;
    logic        rwLat_q, rwLat_d;
    logic [1:0]  nextPhase;
    logic        cycDone;
    logic        phaseBad;

    logic [31:0] cycCount_q;
    logic        stop_q;
    logic        phaseErr_q;
    logic        overflow_q;

    logic [24:0]      mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             fifoFull;
    logic             doPop;
    logic             doPush;
    logic             dropEntry;

    // The input stage is a plain pipeline; it keeps sampling during reset so the FSM
    // resynchronises from the real bus phase rather than from a forced value.
    always_ff @(posedge clk) begin
        qS_q     <= bus.qclk;
        eS_q     <= bus.eclk;
        adrS_q   <= bus.vadr;
        rwS_q    <= bus.rw;
        datS_q   <= bus.data;
        phaseP_q <= {eS_q, qS_q};
    end

    assign phaseS = {eS_q, qS_q};

    always_comb begin
        case (state_q)
            ST_PH00: nextPhase = PH_01;
            ST_PH01: nextPhase = PH_11;
            ST_PH11: nextPhase = PH_10;
            default: nextPhase = PH_00;
        endcase
    end

    // A held phase is always legal; any change must be the single next step of the sequence.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rwLat_d  = rwLat_q;
        cycDone  = 1'b0;
        phaseBad = 1'b0;
        if (state_q == ST_UNSYNC) begin
            if (phaseS == PH_00) begin
                state_d = ST_PH00;
            end
        end else if (state_q > ST_PH10) begin
            state_d = ST_UNSYNC;
        end else if (phaseS != phaseP_q) begin
            if (phaseS != nextPhase) begin
                phaseBad = 1'b1;
                state_d  = ST_UNSYNC;
            end else begin
                case (state_q)
                    ST_PH00: begin
                        state_d = ST_PH01;
                        addr_d  = adrS_q;
                        rwLat_d = rwS_q;
                    end
                    ST_PH01: state_d = ST_PH11;
                    ST_PH11: state_d = ST_PH10;
                    ST_PH10: begin
                        state_d = ST_PH00;
                        cycDone = 1'b1;
                    end
                    default: state_d = ST_UNSYNC;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_UNSYNC;
            addr_q  <= '0;
            rwLat_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rwLat_q <= rwLat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycCount_q <= '0;
            stop_q     <= 1'b0;
            phaseErr_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (cycDone) begin
                cycCount_q <= cycCount_q + 32'd1;
            end
            if (cycDone && (addr_q == STOP_ADDR)) begin
                stop_q <= 1'b1;
            end
            if (phaseBad) begin
                phaseErr_q <= 1'b1;
            end
            if (dropEntry) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign fifoFull  = (count_q == FULL_COUNT);
    assign doPop     = (count_q != '0) && bus.out_ready;
    assign doPush    = cycDone && (!fifoFull || doPop);
    assign dropEntry = cycDone && fifoFull && !doPop;

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (doPush) begin
                mem_q[wrPtr_q] <= {addr_q, rwLat_q, datS_q};
                wrPtr_q        <= wrPtr_q + PTR_ONE;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + PTR_ONE;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + COUNT_ONE;
                2'b01:   count_q <= count_q - COUNT_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_addr  = mem_q[rdPtr_q][24:9];
    assign bus.out_rw    = mem_q[rdPtr_q][8];
    assign bus.out_data  = mem_q[rdPtr_q][7:0];
    assign bus.cyc_count = cycCount_q;
    assign bus.stop      = stop_q;
    assign bus.phase_err = phaseErr_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: doc/mmu09_bus_monitor.md
Name: mmu09_bus_monitor

Overview:
- Synthesizable observer that sits on the MMU09 6809 bus and consumes the E/Q quadrature clocks, address, R/W and data driven by the CPU side of the SBC.
- Checks that the E/Q phase sequence is legal and reconstructs each bus cycle.
- Captures completed cycles into a 4-entry FIFO with a valid/ready read port, counts E cycles and flags accesses to a stop address.
- Used in-FPGA and in simulation as the receiving end of the bus and clock stimulus.

Parameters:
- STOP_ADDR, 16'hFFF0, address that sets the sticky stop flag.
- FIFO_DEPTH, 4, capture FIFO entries; power of two; only 4 is required.

Ports:
- clk  in  1  four-speed system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- qclk  in  1  6809 Q clock, synchronous to clk.
- eclk  in  1  6809 E clock, synchronous to clk.
- vadr  in  16  CPU address bus.
- rw  in  1  CPU R/W (1 = read).
- data  in  8  CPU data bus.
- out_valid  out  1  FIFO head entry available.
- out_ready  in  1  consumer accepts head entry.
- out_addr  out  16  head entry address.
- out_rw  out  1  head entry R/W.
- out_data  out  8  head entry data.
- cyc_count  out  32  number of completed legal bus cycles.
- stop  out  1  sticky; set on a completed cycle at STOP_ADDR.
- phase_err  out  1  sticky; illegal E/Q transition seen.
- overflow  out  1  sticky; a cycle was dropped because the FIFO was full.

Behaviour:
- Reset values: every output is 0. The FIFO is emptied and the FSM enters UNSYNC.
- Reset mid-cycle: the partial cycle is discarded and nothing is pushed.
- Input stage: qclk, eclk, vadr, rw and data are registered once (stage S). A previous copy of (eclk, qclk) is kept as P.
- Phase is encoded as {E,Q}. The only legal sequence is 00 -> 01 -> 11 -> 10 -> 00.
- S == P is always legal, so phases may be stretched by any number of clk cycles.
- FSM states:
  - UNSYNC: wait for S == 00, then go to PH00. No error is raised in UNSYNC.
  - PH00: on 01, latch addr/rw from S and go to PH01.
  - PH01: on 11, go to PH11.
  - PH11: on 10, go to PH10.
  - PH10: on 00 (E fall), latch data from S, complete the cycle and go to PH00.
- Illegal transition from any PHxx state: set phase_err, discard the cycle, go to UNSYNC.
- Address and rw come from the Q-rise sample. Data comes from the E-fall sample, i.e. the S-stage data on the same edge.
- Cycle completion, on the edge after E fall is registered:
  - cyc_count increments and wraps from 0xFFFFFFFF to 0.
  - stop sets if the latched addr == STOP_ADDR.
  - The entry {addr, rw, data} is pushed.
- Latency: eclk is driven low at clk edge N, sampled into S at N+1, and the entry is visible at out_* with out_valid=1 at N+2.
- FIFO:
  - out_* always present the head entry; the values are don't-care when out_valid=0.
  - Pop happens on an edge where out_valid && out_ready.
  - Push when full with no pop: the entry is dropped, overflow sets, and the existing contents are unchanged.
  - Push and pop on the same edge when full: both succeed and the count stays at 4.
  - Push and pop on the same edge when empty: out_valid=0, so there is no pop; the push succeeds.
  - Read and write pointers wrap modulo 4.
- Sticky flags clear only on reset.

Test Plan:
- Clean cycles: drive 3 cycles at 4 clk each with addrs 0x1234 (rw=1, data 0xA5), 0x8000 (rw=0, data 0x3C), 0xC000 (rw=1, data 0xFF), out_ready=1 -> 3 pops in order with matching fields, cyc_count=3, no flags.
- Stretched phases: hold each phase 3 clk, addr 0x0010 -> 1 entry, data captured at E fall only, no phase_err, output 2 clk after E fall.
- Illegal sequence: 00 -> 01 -> 00 mid-cycle -> phase_err=1, no push, cyc_count unchanged. A following full legal cycle after an intervening 00 is captured normally.
- FIFO full and overflow: out_ready=0, 5 cycles at addrs 0..4 -> out_valid=1, entries 0..3 retained, overflow=1. Then out_ready=1 -> pops 0,1,2,3. A push coinciding with a pop while full is accepted.
- Stop address: cycle at 0xFFF0 -> stop=1 two clk after E fall and remains set through subsequent cycles at 0x0000.
- Reset mid-cycle: assert reset in PH11 for 1 clk -> all outputs 0, FIFO empty, the partial cycle is not counted, and the next full cycle gives cyc_count=1.
